// File: rtl/program_loader.sv
// Boot-time program loader: packs a {LEN, HI, LO...} byte stream into
// 15-bit instructions and writes them to instruction memory.
// Optional trailing checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               im_we,
    output logic [ADDR_W-1:0]  im_addr,
    output logic [INSTR_W-1:0] im_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WR,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [8:0]           count_q, count_d;
    logic [8:0]           n_q, n_d;
    logic [6:0]           op_q, op_d;
    logic [INSTR_W-1:0]   wdata_q, wdata_d;
    logic                 in_ready_q;
    logic                 im_we_q;
    logic                 cpu_hold_q;
    logic                 done_q;
    logic                 err_q;
    logic                 accept;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]           sum_q, sum_d;
`endif

    assign accept   = in_valid & in_ready_q;
    assign in_ready = in_ready_q;
    assign im_we    = im_we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

    // Next-state and datapath update for the load sequence
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        n_d     = n_q;
        op_d    = op_q;
        wdata_d = wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    addr_d  = '0;
                    count_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_LEN: begin
                if (accept) begin
                    n_d     = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    state_d = S_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + in_data;
`endif
                end
            end
            S_HI: begin
                if (accept) begin
                    if (in_data[7]) begin
                        state_d = S_ERR;
                    end else begin
                        op_d    = in_data[6:0];
                        state_d = S_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum_d   = sum_q + in_data;
`endif
                    end
                end
            end
            S_LO: begin
                if (accept) begin
                    wdata_d = INSTR_W'({op_q, in_data});
                    state_d = S_WR;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + in_data;
`endif
                end
            end
            S_WR: begin
                count_d = count_q + 9'd1;
                if (count_q + 9'd1 == n_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_HI;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    state_d = (in_data == sum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State register with outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            n_q        <= '0;
            op_q       <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            n_q        <= n_d;
            op_q       <= op_d;
            wdata_q    <= wdata_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            in_ready_q <= (state_d == S_LEN) || (state_d == S_HI) ||
                          (state_d == S_LO)  || (state_d == S_CHK);
`else
            in_ready_q <= (state_d == S_LEN) || (state_d == S_HI) ||
                          (state_d == S_LO);
`endif
            im_we_q    <= (state_d == S_WR);
            cpu_hold_q <= (state_d != S_DONE);
            done_q     <= (state_d == S_DONE);
            err_q      <= (state_d == S_ERR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed loads with a write scoreboard.
// Checks reset, packing, format error, 256-word image, stalls, mid-load reset.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [14:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    bit stall_en = 1'b0;
    logic [22:0] sb[$];
    logic [7:0]  hi_b[256];
    logic [7:0]  lo_b[256];

    program_loader #(.ADDR_W(8), .INSTR_W(15)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            logic [22:0] exp;
            writes++;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed addr %0h expected none",
                       im_addr);
            end
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                checks++;
                assert ({im_addr, im_wdata} === exp) else begin
                    errors++;
                    $error("FAIL write: observed %0h/%0h expected %0h/%0h",
                           im_addr, im_wdata, exp[22:15], exp[14:0]);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        if (stall_en) begin
            int g;
            g = int'($urandom_range(0, 2));
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                start = ($urandom_range(0, 2) == 0);
                @(negedge clk);
            end
            start = 1'b0;
        end
        in_valid = 1'b1;
        in_data = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", 32'(t < 50), 32'd1);
        if (t < 50) begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_image(input int n, input bit bad_sum);
        logic [7:0] sum;
        logic [7:0] lenb;
        pulse_start();
        lenb = 8'(n);
        sum = lenb;
        send(lenb);
        for (int i = 0; i < n; i++) begin
            sb.push_back({8'(i), hi_b[i][6:0], lo_b[i]});
            send(hi_b[i]);
            send(lo_b[i]);
            sum = sum + hi_b[i] + lo_b[i];
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send(bad_sum ? sum + 8'd1 : sum);
`else
        if (bad_sum) sum = 8'd0;
`endif
    endtask

    task automatic wait_level(input bit want_done, input string tag);
        int t;
        t = 0;
        while ((want_done ? done : err) !== 1'b1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done"}, 32'(done), 32'(want_done));
        chk({tag, "_err"}, 32'(err), 32'(!want_done));
        chk({tag, "_hold"}, 32'(cpu_hold), 32'(!want_done));
    endtask

    initial begin
        int w0;
        // Test 1: reset state and idle without start
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_addr", 32'(im_addr), 32'd0);
        chk("rst_wdata", 32'(im_wdata), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_hold", 32'(cpu_hold), 32'd1);
            chk("idle_ready", 32'(in_ready), 32'd0);
        end
        chk("idle_no_we", 32'(writes), 32'd0);

        // Test 2: two-instruction image
        hi_b[0] = 8'h05; lo_b[0] = 8'h0A;
        hi_b[1] = 8'h06; lo_b[1] = 8'hFF;
        run_image(2, 1'b0);
        wait_level(1'b1, "img2");
        chk("img2_writes", 32'(writes), 32'd2);

        // Test 3: HI byte with bit 7 set aborts without a write
        pulse_start();
        chk("restart_hold", 32'(cpu_hold), 32'd1);
        send(8'h01);
        send(8'h85);
        wait_level(1'b0, "fmt");
        in_valid = 1'b1;
        in_data = 8'h00;
        repeat (3) begin
            @(negedge clk);
            chk("err_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        chk("fmt_writes", 32'(writes), 32'd2);
        run_image(2, 1'b0);
        wait_level(1'b1, "recover");

        // Test 4: LEN=0 means 256 words, no wrap write afterwards
        for (int i = 0; i < 256; i++) begin
            hi_b[i] = {1'b0, 7'(i * 3)};
            lo_b[i] = 8'(255 - i);
        end
        w0 = writes;
        run_image(256, 1'b0);
        wait_level(1'b1, "full");
        repeat (5) @(negedge clk);
        chk("full_writes", 32'(writes - w0), 32'd256);
        chk("full_sb_empty", 32'(sb.size()), 32'd0);
        chk("full_last_addr", 32'(im_addr), 32'hFF);

        // Test 5: random stalls and stray start pulses mid-load
        stall_en = 1'b1;
        w0 = writes;
        run_image(20, 1'b0);
        stall_en = 1'b0;
        start = 1'b0;
        wait_level(1'b1, "stall");
        chk("stall_writes", 32'(writes - w0), 32'd20);

        // Test 6: asynchronous reset mid-load
        pulse_start();
        send(8'd3);
        sb.push_back({8'd0, hi_b[0][6:0], lo_b[0]});
        send(hi_b[0]);
        send(lo_b[0]);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(in_ready), 32'd0);
        chk("arst_we", 32'(im_we), 32'd0);
        chk("arst_addr", 32'(im_addr), 32'd0);
        chk("arst_wdata", 32'(im_wdata), 32'd0);
        chk("arst_hold", 32'(cpu_hold), 32'd1);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_sb_empty", 32'(sb.size()), 32'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        run_image(2, 1'b1);
        wait_level(1'b0, "badsum");
`endif
        run_image(2, 1'b0);
        wait_level(1'b1, "final");

        repeat (5) @(negedge clk);
        chk("end_sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
